// File: rtl/led_cube_pkg.sv
// Shared types and sizes for the LED cube frame buffer.
package led_cube_pkg;

  localparam int BYTES_PER_FRAME = 64;
  localparam int LAYERS          = 8;
  localparam int DATA_W          = 8;
  localparam int BYTES_PER_LAYER = BYTES_PER_FRAME / LAYERS;

  typedef logic [63:0]       layer_t;
  typedef logic [5:0]        byte_idx_t;
  typedef logic [2:0]        layer_idx_t;
  typedef logic [DATA_W-1:0] byte_t;

  localparam byte_idx_t FIRST_IDX = 6'd0;
  localparam byte_idx_t LAST_IDX  = 6'd63;

endpackage

// File: rtl/led_cube_frame_bank.sv
// One 64-byte frame bank held in flops so that reset can clear every LED.
// Single byte write port and a combinational read of one whole layer.
module led_cube_frame_bank
  import led_cube_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  byte_idx_t  waddr,
  input  byte_t      wdata,
  input  layer_idx_t layer_idx,
  output layer_t     layer_out
);

  byte_t mem_q [BYTES_PER_FRAME];
  byte_t mem_d [BYTES_PER_FRAME];

  // Next-state of the storage: hold, or replace the addressed byte.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // Storage register with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BYTES_PER_FRAME; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Layer read: lowest-addressed byte of the layer lands in the low bits.
  always_comb begin
    layer_out = '0;
    for (int b = 0; b < BYTES_PER_LAYER; b++) begin
      layer_out[DATA_W*b +: DATA_W] = mem_q[{layer_idx, 3'(b)}];
    end
  end

endmodule

// File: rtl/led_cube_frame_buffer.sv
// Double-buffered frame store between the cube stream controller and the
// layer scanner. Bytes land in the back bank; the back bank becomes the
// front only on a refresh boundary, so the scanner never sees a torn frame.
module led_cube_frame_buffer
  import led_cube_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        new_data,
  input  logic [7:0]  data_in,
  input  logic        stream_active,
  input  logic        refresh_done,
  input  logic [2:0]  layer_sel,
  output logic [63:0] layer_data,
  output logic        frame_swapped,
  output logic        frame_pending,
  output logic [7:0]  dropped_frames,
  output logic [7:0]  aborted_frames
);

  byte_idx_t  wr_ptr_q, wr_ptr_d;
  logic       drop_q, drop_d;
  logic       front_sel_q, front_sel_d;
  logic       pending_q, pending_d;
  logic       swapped_q, swapped_d;
  logic       stream_active_q, stream_active_d;
  logic [7:0] dropped_q, dropped_d;
  logic [7:0] aborted_q, aborted_d;
  layer_t     layer_data_q, layer_data_d;

  logic   swap, abort, start_drop, wr_en;
  logic   bank0_we, bank1_we;
  layer_t bank0_layer, bank1_layer;

  // Event decode. A frame-start byte only drops when no swap is about to
  // free the back bank in the same cycle.
  assign swap       = refresh_done && pending_q;
  assign abort      = stream_active_q && !stream_active && (wr_ptr_q != FIRST_IDX);
  assign start_drop = new_data && !abort && !drop_q && (wr_ptr_q == FIRST_IDX)
                      && pending_q && !refresh_done;
  assign wr_en      = new_data && !abort && !drop_q && !start_drop;

  // Write pointer, drop flag, bank select, pending flag and counters.
  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    drop_d          = drop_q;
    front_sel_d     = front_sel_q;
    pending_d       = pending_q;
    dropped_d       = dropped_q;
    aborted_d       = aborted_q;
    swapped_d       = swap;
    stream_active_d = stream_active;

    if (swap) begin
      front_sel_d = ~front_sel_q;
      pending_d   = 1'b0;
    end

    if (abort) begin
      wr_ptr_d = FIRST_IDX;
      drop_d   = 1'b0;
      if (!drop_q && aborted_q != 8'hFF) aborted_d = aborted_q + 8'd1;
    end else if (new_data) begin
      wr_ptr_d = wr_ptr_q + 6'd1;
      if (start_drop) begin
        drop_d = 1'b1;
        if (dropped_q != 8'hFF) dropped_d = dropped_q + 8'd1;
      end else if (drop_q && wr_ptr_q == LAST_IDX) begin
        drop_d = 1'b0;
      end
      if (wr_en && wr_ptr_q == LAST_IDX) pending_d = 1'b1;
    end
  end

  // Writes target the bank that is back after any same-cycle swap.
  assign bank0_we = wr_en && front_sel_d;
  assign bank1_we = wr_en && !front_sel_d;

  led_cube_frame_bank u_bank0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (bank0_we),
    .waddr     (wr_ptr_q),
    .wdata     (data_in),
    .layer_idx (layer_sel),
    .layer_out (bank0_layer)
  );

  led_cube_frame_bank u_bank1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (bank1_we),
    .waddr     (wr_ptr_q),
    .wdata     (data_in),
    .layer_idx (layer_sel),
    .layer_out (bank1_layer)
  );

  // Front-bank layer mux feeding the output register.
  always_comb begin
    layer_data_d = front_sel_q ? bank1_layer : bank0_layer;
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q        <= FIRST_IDX;
      drop_q          <= 1'b0;
      front_sel_q     <= 1'b0;
      pending_q       <= 1'b0;
      swapped_q       <= 1'b0;
      stream_active_q <= 1'b0;
      dropped_q       <= '0;
      aborted_q       <= '0;
      layer_data_q    <= '0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      drop_q          <= drop_d;
      front_sel_q     <= front_sel_d;
      pending_q       <= pending_d;
      swapped_q       <= swapped_d;
      stream_active_q <= stream_active_d;
      dropped_q       <= dropped_d;
      aborted_q       <= aborted_d;
      layer_data_q    <= layer_data_d;
    end
  end

  assign layer_data     = layer_data_q;
  assign frame_swapped  = swapped_q;
  assign frame_pending  = pending_q;
  assign dropped_frames = dropped_q;
  assign aborted_frames = aborted_q;

endmodule
